// File: rtl/pass_request_ctrl.sv
// pass_request_ctrl: synchronise/debounce a pedestrian button, hold the request until the light is not green, pulse pass, then lock out.
// Defining PASS_STAT_EN adds a 16-bit wrapping pass_cnt output counting pass pulses.
module pass_request_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int DB_CYCLES      = 16,
    parameter int HOLDOFF_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_raw,
    input  logic        g_in,
    output logic        pass,
    output logic        pending,
`ifdef PASS_STAT_EN
    output logic        busy,
    output logic [15:0] pass_cnt
`else
    output logic        busy
`endif
);
    localparam int CMAX = DB_CYCLES > HOLDOFF_CYCLES ? DB_CYCLES : HOLDOFF_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] HO_LAST = CW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        DEBOUNCE     = 3'd1,
        PENDING      = 3'd2,
        HOLDOFF      = 3'd3,
        WAIT_RELEASE = 3'd4
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_s;

    assign btn_s   = sync[SYNC_STAGES-1];
    assign pending = state == PENDING;
    assign busy    = state == HOLDOFF || state == WAIT_RELEASE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= '0;
        else      sync <= {sync[SYNC_STAGES-2:0], btn_raw};
    end

    // cnt is cleared on every transition so each state starts counting from zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            pass  <= 1'b0;
        end else begin
            pass <= 1'b0;
            case (state)
                IDLE: if (btn_s) begin
                    state <= DEBOUNCE;
                    cnt   <= '0;
                end
                DEBOUNCE: if (!btn_s) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (cnt == DB_LAST) begin
                    state <= PENDING;
                    cnt   <= '0;
                end else cnt <= cnt + CW'(1);
                PENDING: if (!g_in) begin
                    state <= HOLDOFF;
                    cnt   <= '0;
                    pass  <= 1'b1;
                end
                HOLDOFF: if (cnt == HO_LAST) begin
                    state <= btn_s ? WAIT_RELEASE : IDLE;
                    cnt   <= '0;
                end else cnt <= cnt + CW'(1);
                WAIT_RELEASE: if (!btn_s) begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PASS_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         pass_cnt <= '0;
        else if (state == PENDING && !g_in) pass_cnt <= pass_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pass_request_ctrl.sv
// tb_pass_request_ctrl: directed stimulus with a run-length/lockout reference model checked every cycle.
module tb_pass_request_ctrl;
    localparam int SYNC = 2, DB = 16, HOLD = 1024;

    logic clk = 0, rst = 0, btn_raw = 0, g_in = 0;
    logic pass, pending, busy;
`ifdef PASS_STAT_EN
    logic [15:0] pass_cnt;
`endif

    pass_request_ctrl #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .HOLDOFF_CYCLES(HOLD)) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .g_in(g_in),
        .pass(pass),
        .pending(pending),
`ifdef PASS_STAT_EN
        .busy(busy),
        .pass_cnt(pass_cnt)
`else
        .busy(busy)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, pass_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: a press is accepted once DB+1 consecutive synchronised-high samples are seen while ready
    bit q[$];
    bit b, pend = 0, waitr = 0, pass_e = 0;
    int run = 0, lock = 0, pc = 0;

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            repeat (SYNC) q.push_back(1'b0);
            run = 0; lock = 0; pend = 0; waitr = 0; pass_e = 0; pc = 0;
        end else begin
            q.push_back(btn_raw);
            b = q.pop_front();
            pass_e = 0;
            if (pend) begin
                if (!g_in) begin
                    pend = 0; pass_e = 1; lock = HOLD; pc = (pc + 1) % 65536;
                end
            end else if (lock > 0) begin
                lock--;
                if (lock == 0) waitr = b;
            end else if (waitr) waitr = b;
            else begin
                run = b ? run + 1 : 0;
                if (run == DB + 1) begin pend = 1; run = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_pass", pass, 0);
            chk("rst_pending", pending, 0);
            chk("rst_busy", busy, 0);
        end else begin
            chk("pass", pass, pass_e);
            chk("pending", pending, pend);
            chk("busy", busy, (lock > 0) || waitr);
`ifdef PASS_STAT_EN
            chk("pass_cnt", pass_cnt, pc);
`endif
            if (pass) pass_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int p0;

    initial begin
        rst = 0; btn_raw = 1; g_in = 0;
        step(3);
        chk("t1_pass", pass, 0);
        chk("t1_pending", pending, 0);
        chk("t1_busy", busy, 0);
        rst = 1;
        for (int i = 1; i <= 19; i++) begin
            step(1);
            chk("t1_nopass", pass, 0);
        end
        step(1);
        chk("t2_pass19", pass, 1);
        step(1);
        chk("t2_pass20", pass, 0);
        chk("t2_busy20", busy, 1);
        step(1022);
        chk("t2_busy_holdoff", busy, 1);
        step(1);
        chk("t2_busy_waitrel", busy, 1);
        chk("t2_pending_waitrel", pending, 0);
        btn_raw = 0;
        step(2);
        chk("t2_busy_sync", busy, 1);
        step(1);
        chk("t2_idle", busy, 0);

        step(5);
        p0 = pass_seen;
        btn_raw = 1; step(10);
        btn_raw = 0; step(1);
        btn_raw = 1; step(10);
        btn_raw = 0; step(30);
        chk("t3_pending", pending, 0);
        chk("t3_passes", pass_seen, p0);

        g_in = 1;
        btn_raw = 1; step(20);
        btn_raw = 0; step(80);
        chk("t4_pending", pending, 1);
        chk("t4_nopass", pass, 0);
        g_in = 0;
        step(1);
        chk("t4_pass", pass, 1);
        chk("t4_pending_clr", pending, 0);
        step(1100);

        p0 = pass_seen;
        btn_raw = 1; step(20);
        chk("t5_pass1", pass, 1);
        btn_raw = 0; step(200);
        btn_raw = 1; step(20);
        btn_raw = 0; step(10);
        chk("t5_lock_pending", pending, 0);
        chk("t5_lock_busy", busy, 1);
        chk("t5_lock_passes", pass_seen, p0 + 1);
        step(1000);
        btn_raw = 1; step(20);
        chk("t5_pass2", pass, 1);
        btn_raw = 0;
`ifdef PASS_STAT_EN
        chk("t6_cnt_before", pass_cnt, 4);
`endif
        #2 rst = 0;
        #1;
        chk("t6_pass_drop", pass, 0);
        chk("t6_busy_drop", busy, 0);
`ifdef PASS_STAT_EN
        chk("t6_cnt_after", pass_cnt, 0);
`endif
        step(2);
        rst = 1;
        step(5);

        g_in = 1;
        btn_raw = 1; step(20);
        btn_raw = 0; step(5);
        chk("t6_pending", pending, 1);
        #2 rst = 0;
        #1;
        chk("t6_pending_drop", pending, 0);
        chk("t6_busy_zero", busy, 0);
        chk("t6_pass_zero", pass, 0);
        step(2);
        rst = 1; g_in = 0;
        step(30);
        chk("t6_no_request", pending, 0);
        chk("t6_no_pass", pass, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
